inst_decode_stage: RTL and testbench
====================================

Name: inst_decode_stage

Overview:
Registered, parametrised instruction-decode stage placed between instruction fetch and the register file/ALU. It splits a 32-bit RV32I instruction into opcode, funct3, funct7 and the rs1/rs2/rd indices. It also generates the format-specific sign-extended immediate (I/S/B/U/J), carries the PC, and flags illegal encodings. Both sides use valid/ready handshakes, with a skid register so the upstream ready signal is purely registered. The stage supports pipeline flush.

Parameters:
XLEN, 32, width of PC and immediate outputs (32 or 64); immediates are sign-extended to XLEN.
SKID_EN, 1, 1 = two-entry buffer (main + skid), inst_ready registered; 0 = single entry, inst_ready = !out_valid | dec_ready.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard all buffered entries
inst_valid  in  1  upstream instruction valid
inst_ready  out  1  stage can accept
inst_data  in  32  raw instruction word
inst_pc  in  XLEN  PC of inst_data
dec_valid  out  1  decoded bundle valid
dec_ready  in  1  downstream accepts bundle
opcode  out  7  inst[6:0]
funct3  out  3  inst[14:12]
funct7  out  7  inst[31:25]
rR1  out  5  inst[19:15]
rR2  out  5  inst[24:20]
wR  out  5  inst[11:7]
imm  out  XLEN  decoded immediate
dec_pc  out  XLEN  PC of the bundle
illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst=1): dec_valid=0, skid empty, every bundle output = 0, inst_ready=1 once reset is released.
- Transfers: input on inst_valid & inst_ready; output on dec_valid & dec_ready; both sampled at the rising edge of clk.
- Latency: an accepted instruction appears on dec_valid the next cycle if the main register is empty or draining. Throughput is 1/cycle when dec_ready=1.
- All bundle outputs are registered. They hold stable while dec_valid=1 & dec_ready=0.
- Buffer states (SKID_EN=1): EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
  - EMPTY: accept -> ONE.
  - ONE, accept & no drain -> FULL (the new entry goes to skid).
  - ONE, accept & drain -> ONE (main reloads).
  - ONE, drain only -> EMPTY.
  - FULL, drain -> ONE (skid moves to main).
  - inst_ready = !FULL, registered.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Immediate by opcode (decode performed before registering):
  - 0010011/0000011/1100111 (I): sext(inst[31:20]).
  - 0100011 (S): sext({inst[31:25],inst[11:7]}).
  - 1100011 (B): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111/0010111 (U): sext({inst[31:12],12'b0}).
  - 1101111 (J): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 0110011 (R), 1110011 (SYSTEM), 0001111 (FENCE): imm=0.
  - Any other opcode: illegal=1, imm=0. Raw fields are still passed through and the bundle still flows; it is not dropped.
- Field outputs are raw bit slices regardless of format.
- flush=1: at the next edge dec_valid=0, skid cleared, state EMPTY. An input offered in the same cycle is consumed and discarded (inst_ready stays as computed). Flush has priority over accept and drain.
- rst asserted mid-transfer: state clears immediately; the in-flight bundle is lost.
- Bundle outputs need not clear on drain; only dec_valid qualifies them.

Test Plan:
- Reset: rst=1 mid-stream -> dec_valid=0 and all outputs 0 immediately; inst_ready=1 the cycle after release.
- I-type: 0xFFF00093 (addi x1,x0,-1), pc=0x100, dec_ready=1 -> next cycle dec_valid=1, opcode=0x13, wR=1, rR1=0, imm=0xFFFFFFFF, dec_pc=0x100, illegal=0.
- S/B/U formats back-to-back: 0x0020A423 -> imm=0x8, rR1=1, rR2=2, funct3=2; 0xFE000EE3 -> imm=0xFFFFFFFC; 0x123452B7 -> imm=0x12345000, wR=5; one bundle per cycle, in order.
- Backpressure: dec_ready=0 while sending A, B, C on consecutive cycles -> A held on outputs, B in skid, inst_ready=0 from cycle 3 so C is stalled. Raising dec_ready yields A, B, C in order with no loss.
- Flush: state FULL, then flush=1 with inst_valid=1 -> next cycle dec_valid=0, inst_ready=1; the flushed entries and the same-cycle input never appear.
- Illegal: 0x00000000 -> dec_valid=1, illegal=1, imm=0, opcode=0; with XLEN=64, addi -1 -> imm=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/inst_decode_stage_if.sv
// Valid/ready bus between fetch, the decode stage and the register-file/ALU side.
// The slave modport is the decode stage itself; master is the surrounding pipeline.
interface inst_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rR1;
    logic [4:0]      rR2;
    logic [4:0]      wR;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] dec_pc;
    logic            illegal;

    modport master (
        output inst_valid, inst_data, inst_pc, dec_ready,
        input  inst_ready, dec_valid, opcode, funct3, funct7,
               rR1, rR2, wR, imm, dec_pc, illegal
    );

    modport slave (
        input  inst_valid, inst_data, inst_pc, dec_ready,
        output inst_ready, dec_valid, opcode, funct3, funct7,
               rR1, rR2, wR, imm, dec_pc, illegal
    );
endinterface

// File: rtl/inst_decode_stage.sv
// RV32I decode stage: field split, sign-extended immediate, illegal-opcode flag,
// with a main + skid buffer so inst_ready comes straight from a flop.
module inst_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    inst_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    buf_state_e state_d, state_q;
    bundle_t    main_d, main_q;
    bundle_t    skid_d, skid_q;
    bundle_t    dec_in;
    logic       rdy_d, rdy_q;
    logic       inst_ready_w;
    logic       accept, drain;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic        known;

    // Immediates are assembled at 32 bits, then sign-extended to XLEN in one place.
    always_comb begin
        inst  = bus.inst_data;
        imm32 = '0;
        known = 1'b1;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            7'b0100011:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {inst[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            7'b0110011, 7'b1110011, 7'b0001111:
                imm32 = '0;
            default:
                known = 1'b0;
        endcase

        dec_in.opcode  = inst[6:0];
        dec_in.funct3  = inst[14:12];
        dec_in.funct7  = inst[31:25];
        dec_in.rs1     = inst[19:15];
        dec_in.rs2     = inst[24:20];
        dec_in.rd      = inst[11:7];
        dec_in.imm     = XLEN'($signed(imm32));
        dec_in.pc      = bus.inst_pc;
        dec_in.illegal = !known;
    end

    // Without the skid entry, ready must look through to dec_ready to keep 1/cycle.
    assign inst_ready_w = SKID_EN ? rdy_q : ((state_q == EMPTY) || bus.dec_ready);
    assign accept       = bus.inst_valid && inst_ready_w;
    assign drain        = (state_q != EMPTY) && bus.dec_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec_in;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = dec_in;
                    end else if (accept && SKID_EN) begin
                        skid_d  = dec_in;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.inst_ready = inst_ready_w;
    assign bus.dec_valid  = (state_q != EMPTY);
    assign bus.opcode     = main_q.opcode;
    assign bus.funct3     = main_q.funct3;
    assign bus.funct7     = main_q.funct7;
    assign bus.rR1        = main_q.rs1;
    assign bus.rR2        = main_q.rs2;
    assign bus.wR         = main_q.rd;
    assign bus.imm        = main_q.imm;
    assign bus.dec_pc     = main_q.pc;
    assign bus.illegal    = main_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Drives a 32-bit and a 64-bit decode stage in lockstep and checks both against
// a two-deep FIFO model with immediates rebuilt from shift arithmetic.
module tb_inst_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    inst_decode_stage_if #(.XLEN(32)) b32 ();
    inst_decode_stage_if #(.XLEN(64)) b64 ();

    inst_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
    inst_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic        cur_v = 1'b0;
    logic        cur_rdy = 1'b0;
    logic [31:0] cur_inst = '0;
    logic [63:0] cur_pc = '0;
    bit          last_acc = 1'b0;

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint s;
        s = longint'($signed(i));
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return s >>> 20;
            7'h23: return ((s >>> 25) << 5) | longint'(i[11:7]);
            7'h63: return ((s >>> 31) << 12) | (longint'(i[7]) << 11)
                          | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            7'h37, 7'h17: return s & ~64'hFFF;
            7'h6F: return ((s >>> 31) << 20) | (longint'(i[19:12]) << 12)
                          | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h73, 7'h0F: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        cur_v = v; cur_inst = inst; cur_pc = pc; cur_rdy = rdy; flush = fl;
        b32.inst_valid = v; b32.inst_data = inst; b32.inst_pc = pc[31:0]; b32.dec_ready = rdy;
        b64.inst_valid = v; b64.inst_data = inst; b64.inst_pc = pc;       b64.dec_ready = rdy;
    endtask

    task automatic check_outputs();
        ent_t e;
        logic [63:0] ei;
        chk("dec_valid32", b32.dec_valid, q.size() > 0);
        chk("inst_ready32", b32.inst_ready, q.size() < 2);
        chk("dec_valid64", b64.dec_valid, q.size() > 0);
        chk("inst_ready64", b64.inst_ready, q.size() < 2);
        if (q.size() > 0) begin
            e  = q[0];
            ei = ref_imm(e.inst);
            chk("opcode32", b32.opcode, e.inst[6:0]);
            chk("funct3_32", b32.funct3, e.inst[14:12]);
            chk("funct7_32", b32.funct7, e.inst[31:25]);
            chk("rR1_32", b32.rR1, e.inst[19:15]);
            chk("rR2_32", b32.rR2, e.inst[24:20]);
            chk("wR32", b32.wR, e.inst[11:7]);
            chk("imm32", b32.imm, {32'b0, ei[31:0]});
            chk("pc32", b32.dec_pc, {32'b0, e.pc[31:0]});
            chk("illegal32", b32.illegal, ref_illegal(e.inst));
            chk("opcode64", b64.opcode, e.inst[6:0]);
            chk("imm64", b64.imm, ei);
            chk("pc64", b64.dec_pc, e.pc);
            chk("illegal64", b64.illegal, ref_illegal(e.inst));
        end
    endtask

    // One clock: update the FIFO model with what the edge sees, then check at negedge.
    task automatic step();
        bit acc, drn;
        @(posedge clk);
        acc = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else begin
            acc = cur_v && (q.size() < 2);
            drn = (q.size() > 0) && cur_rdy;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{cur_inst, cur_pc});
        end
        last_acc = acc;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain_all();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4 && q.size() > 0; k++) step();
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid32"}, b32.dec_valid, 0);
        chk({tag, "_valid64"}, b64.dec_valid, 0);
        chk({tag, "_imm64"}, b64.imm, 0);
        chk({tag, "_pc64"}, b64.dec_pc, 0);
        chk({tag, "_bits32"}, {b32.opcode, b32.funct3, b32.funct7, b32.rR1, b32.rR2,
                               b32.wR, b32.illegal}, 0);
        chk({tag, "_imm32"}, b32.imm, 0);
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h00};

    initial begin
        logic [31:0] ri;
        logic [63:0] rp;
        logic [63:0] head_pc;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state
        #2 check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("ready_after_rst", b32.inst_ready, 1);

        // I-type addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
        step();
        chk("i_opcode", b32.opcode, 7'h13);
        chk("i_wR", b32.wR, 5'd1);
        chk("i_rR1", b32.rR1, 5'd0);
        chk("i_imm", b32.imm, 32'hFFFFFFFF);
        chk("i_pc", b32.dec_pc, 32'h100);
        chk("i_illegal", b32.illegal, 0);
        chk("i_imm64", b64.imm, 64'hFFFF_FFFF_FFFF_FFFF);

        // S, B, U back to back
        drive(1'b1, 32'h0020A423, 64'h104, 1'b1, 1'b0);
        step();
        chk("s_imm", b32.imm, 32'h8);
        chk("s_rR1", b32.rR1, 5'd1);
        chk("s_rR2", b32.rR2, 5'd2);
        chk("s_funct3", b32.funct3, 3'd2);
        drive(1'b1, 32'hFE000EE3, 64'h108, 1'b1, 1'b0);
        step();
        chk("b_imm", b32.imm, 32'hFFFFFFFC);
        drive(1'b1, 32'h123452B7, 64'h10C, 1'b1, 1'b0);
        step();
        chk("u_imm", b32.imm, 32'h12345000);
        chk("u_wR", b32.wR, 5'd5);
        drain_all();

        // Backpressure: A and B fill the buffer, C must stall until drain
        drive(1'b1, 32'h00100113, 64'h200, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00200193, 64'h204, 1'b0, 1'b0);
        step();
        chk("bp_ready_low", b32.inst_ready, 0);
        drive(1'b1, 32'h00300213, 64'h208, 1'b0, 1'b0);
        step();
        chk("bp_c_stalled", last_acc, 0);
        chk("bp_hold_a", b32.dec_pc, 32'h200);
        drive(1'b1, 32'h00300213, 64'h208, 1'b1, 1'b0);
        head_pc = 64'h200;
        for (int k = 0; k < 8 && !last_acc; k++) begin
            step();
            if (q.size() > 0 && q[0].pc != head_pc) head_pc = q[0].pc;
        end
        chk("bp_c_accepted", last_acc, 1);
        drain_all();

        // Flush from FULL with a same-cycle input
        drive(1'b1, 32'h00500293, 64'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00600313, 64'h304, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h00700393, 64'h308, 1'b0, 1'b1);
        step();
        chk("fl_valid", b32.dec_valid, 0);
        chk("fl_ready", b32.inst_ready, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        chk("fl_stays_empty", b64.dec_valid, 0);

        // Illegal all-zero word still flows
        drive(1'b1, 32'h00000000, 64'h400, 1'b1, 1'b0);
        step();
        chk("ill_valid", b32.dec_valid, 1);
        chk("ill_flag", b32.illegal, 1);
        chk("ill_imm", b32.imm, 0);
        chk("ill_opcode", b32.opcode, 0);
        drain_all();

        // Randomised traffic with flushes and one asynchronous reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                #1 rst = 1'b1;
                #1 check_reset_outputs("midrst");
                drive(1'b1, $urandom, {$urandom, $urandom}, 1'b1, 1'b0);
                step();
                rst = 1'b0;
                drive(1'b0, '0, '0, 1'b1, 1'b0);
                step();
                chk("midrst_ready", b32.inst_ready, 1);
            end
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 11) == 0) ri[6:0] = 7'($urandom);
            rp = {$urandom, $urandom};
            drive($urandom_range(0, 9) < 7, ri, rp, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
